ddr_init_seq: RTL and testbench

- DDR3 power-up/initialisation sequencer; sits directly downstream of the top-level controller FSM.
- Triggered by ddr_init_start. Drives the DRAM reset/CKE/command pins through the DFI command path while the controller's DFI mux routes this block (sel = 01).
- Performs reset, CKE bring-up, MR2/MR3/MR1/MR0 programming and ZQCL calibration, then raises ddr_init_done.

---
 rtl/ddr_init_seq.sv | 219 +++++++++++++++++++++
 tb/tb_ddr_init_seq.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ddr_init_seq.sv
// ddr_init_seq
// DDR3 power-up / initialisation sequencer. After ddr_init_start is sampled
// high in IDLE it holds RESET# low, releases it, raises CKE, issues MR2, MR3,
// MR1 and MR0 mode-register sets, then ZQCL, waits for ZQ init and reports
// ddr_init_done. Every output is registered on the same edge as the state.
//
// Ports
//   core_clk, core_rst   clock and synchronous active-high reset
//   ddr_init_start       level request from the controller FSM
//   ddr_init_done        initialisation complete (held while start stays high)
//   busy                 sequence in progress (not IDLE, not DONE)
//   dfi_reset_n, dfi_cke DRAM RESET# and CKE
//   dfi_cs_n/ras_n/cas_n/we_n, dfi_bank, dfi_address   DFI command path
//   dfi_odt              ODT, held 0

module ddr_init_seq #(
  parameter int ADDR_W   = 14,
  parameter int CNT_W    = 20,
  parameter int T_RESET  = 40000,
  parameter int T_CKE    = 100000,
  parameter int T_XPR    = 64,
  parameter int T_MRD    = 4,
  parameter int T_MOD    = 12,
  parameter int T_ZQINIT = 512,
  parameter logic [ADDR_W-1:0] MR0_VAL = 'h0520,
  parameter logic [ADDR_W-1:0] MR1_VAL = 'h0044,
  parameter logic [ADDR_W-1:0] MR2_VAL = 'h0008,
  parameter logic [ADDR_W-1:0] MR3_VAL = 'h0000
) (
  input  logic              core_clk,
  input  logic              core_rst,
  input  logic              ddr_init_start,
  output logic              ddr_init_done,
  output logic              busy,
  output logic              dfi_reset_n,
  output logic              dfi_cke,
  output logic              dfi_cs_n,
  output logic              dfi_ras_n,
  output logic              dfi_cas_n,
  output logic              dfi_we_n,
  output logic [2:0]        dfi_bank,
  output logic [ADDR_W-1:0] dfi_address,
  output logic              dfi_odt
);

  // A zero timing parameter behaves as a one-cycle phase.
  localparam int T_RESET_E  = (T_RESET  < 1) ? 1 : T_RESET;
  localparam int T_CKE_E    = (T_CKE    < 1) ? 1 : T_CKE;
  localparam int T_XPR_E    = (T_XPR    < 1) ? 1 : T_XPR;
  localparam int T_MRD_E    = (T_MRD    < 1) ? 1 : T_MRD;
  localparam int T_MOD_E    = (T_MOD    < 1) ? 1 : T_MOD;
  localparam int T_ZQINIT_E = (T_ZQINIT < 1) ? 1 : T_ZQINIT;

  localparam logic [CNT_W-1:0] LD_RESET = CNT_W'(T_RESET_E - 1);
  localparam logic [CNT_W-1:0] LD_CKE   = CNT_W'(T_CKE_E - 1);
  localparam logic [CNT_W-1:0] LD_XPR   = CNT_W'(T_XPR_E - 1);
  localparam logic [CNT_W-1:0] LD_MRD   = CNT_W'(T_MRD_E - 1);
  localparam logic [CNT_W-1:0] LD_MOD   = CNT_W'(T_MOD_E - 1);
  // The ZQCL cycle itself counts toward T_ZQINIT, so ZQ_WAIT covers the rest.
  localparam logic [CNT_W-1:0] LD_ZQ   = CNT_W'((T_ZQINIT_E > 1) ? T_ZQINIT_E - 2 : 0);

  typedef enum logic [3:0] {
    IDLE, RST_LOW, CKE_WAIT, XPR, MR2, MR3, MR1, MR0, ZQCL, ZQ_WAIT, DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d, busy_q, busy_d;
  logic              reset_n_q, reset_n_d, cke_q, cke_d;
  logic              cs_n_q, cs_n_d, ras_n_q, ras_n_d, cas_n_q, cas_n_d, we_n_q, we_n_d;
  logic [2:0]        bank_q, bank_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic              cnt_zero, entering;

  assign cnt_zero = (cnt_q == '0);

  // Next-state and phase counter. Each timed phase loads (T-1) on entry and
  // leaves when the counter reaches zero; the counter never wraps below zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_zero ? cnt_q : cnt_q - 1'b1;
    case (state_q)
      IDLE: begin
        cnt_d = cnt_q;
        if (ddr_init_start) begin
          state_d = RST_LOW;
          cnt_d   = LD_RESET;
        end
      end
      RST_LOW:  if (cnt_zero) begin state_d = CKE_WAIT; cnt_d = LD_CKE; end
      CKE_WAIT: if (cnt_zero) begin state_d = XPR;      cnt_d = LD_XPR; end
      XPR:      if (cnt_zero) begin state_d = MR2;      cnt_d = LD_MRD; end
      MR2:      if (cnt_zero) begin state_d = MR3;      cnt_d = LD_MRD; end
      MR3:      if (cnt_zero) begin state_d = MR1;      cnt_d = LD_MRD; end
      MR1:      if (cnt_zero) begin state_d = MR0;      cnt_d = LD_MOD; end
      MR0:      if (cnt_zero) begin state_d = ZQCL;     cnt_d = '0;     end
      ZQCL: begin
        cnt_d   = LD_ZQ;
        state_d = (T_ZQINIT_E > 1) ? ZQ_WAIT : DONE;
      end
      ZQ_WAIT:  if (cnt_zero) begin state_d = DONE;     cnt_d = '0;     end
      DONE: begin
        cnt_d = cnt_q;
        if (!ddr_init_start) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign entering = (state_d != state_q);

  // Pin values are decoded from the state being entered so they appear on
  // the same edge as the state register. MRS states carry their command only
  // on their first cycle and NOP for the remaining spacing cycles.
  always_comb begin
    done_d    = 1'b0;
    busy_d    = 1'b0;
    reset_n_d = 1'b0;
    cke_d     = 1'b0;
    cs_n_d    = 1'b1;
    ras_n_d   = 1'b1;
    cas_n_d   = 1'b1;
    we_n_d    = 1'b1;
    bank_d    = 3'd0;
    address_d = '0;
    case (state_d)
      RST_LOW:  busy_d = 1'b1;
      CKE_WAIT: begin
        busy_d    = 1'b1;
        reset_n_d = 1'b1;
      end
      XPR, ZQ_WAIT: begin
        busy_d    = 1'b1;
        reset_n_d = 1'b1;
        cke_d     = 1'b1;
        cs_n_d    = 1'b0;
      end
      MR2, MR3, MR1, MR0: begin
        busy_d    = 1'b1;
        reset_n_d = 1'b1;
        cke_d     = 1'b1;
        cs_n_d    = 1'b0;
        if (entering) begin
          ras_n_d = 1'b0;
          cas_n_d = 1'b0;
          we_n_d  = 1'b0;
          case (state_d)
            MR2:     begin bank_d = 3'd2; address_d = MR2_VAL; end
            MR3:     begin bank_d = 3'd3; address_d = MR3_VAL; end
            MR1:     begin bank_d = 3'd1; address_d = MR1_VAL; end
            default: begin bank_d = 3'd0; address_d = MR0_VAL; end
          endcase
        end
      end
      ZQCL: begin
        busy_d        = 1'b1;
        reset_n_d     = 1'b1;
        cke_d         = 1'b1;
        cs_n_d        = 1'b0;
        we_n_d        = 1'b0;
        address_d[10] = 1'b1;
      end
      DONE: begin
        done_d    = 1'b1;
        reset_n_d = 1'b1;
        cke_d     = 1'b1;
        cs_n_d    = 1'b0;
      end
      default: ;
    endcase
  end

  // State, counter and registered pins; reset values equal the IDLE pins.
  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      reset_n_q <= 1'b0;
      cke_q     <= 1'b0;
      cs_n_q    <= 1'b1;
      ras_n_q   <= 1'b1;
      cas_n_q   <= 1'b1;
      we_n_q    <= 1'b1;
      bank_q    <= 3'd0;
      address_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      reset_n_q <= reset_n_d;
      cke_q     <= cke_d;
      cs_n_q    <= cs_n_d;
      ras_n_q   <= ras_n_d;
      cas_n_q   <= cas_n_d;
      we_n_q    <= we_n_d;
      bank_q    <= bank_d;
      address_q <= address_d;
    end
  end

  assign ddr_init_done = done_q;
  assign busy          = busy_q;
  assign dfi_reset_n   = reset_n_q;
  assign dfi_cke       = cke_q;
  assign dfi_cs_n      = cs_n_q;
  assign dfi_ras_n     = ras_n_q;
  assign dfi_cas_n     = cas_n_q;
  assign dfi_we_n      = we_n_q;
  assign dfi_bank      = bank_q;
  assign dfi_address   = address_q;
  assign dfi_odt       = 1'b0;

endmodule

// File: tb/tb_ddr_init_seq.sv
// tb_ddr_init_seq
// Drives two sequencers from the same start/reset stimulus: one with short
// timing parameters and one with every timing parameter at zero. Expected pin
// values come from a cycle-offset model: the bench tracks how many cycles
// have passed since the first RESET#-low cycle and derives each pin from the
// documented event times (MR2 at tR+tC+tX, MRS spacing tMrd, and so on).

module tb_ddr_init_seq;

  logic core_clk = 1'b0;
  logic core_rst = 1'b1;
  logic ddr_init_start = 1'b0;

  logic        doneA, busyA, rstnA, ckeA, csA, rasA, casA, weA, odtA;
  logic [2:0]  bankA;
  logic [13:0] addrA;
  logic        doneZ, busyZ, rstnZ, ckeZ, csZ, rasZ, casZ, weZ, odtZ;
  logic [2:0]  bankZ;
  logic [13:0] addrZ;

  int checkCount = 0;
  int failCount  = 0;

  // Model state: mode 0 = idle, 1 = running (k = cycles since RST_LOW), 2 = done.
  int modeA = 0, kA = 0, modeZ = 0, kZ = 0;

  always #5 core_clk = ~core_clk;

  ddr_init_seq #(
    .T_RESET(4), .T_CKE(5), .T_XPR(3), .T_MRD(4), .T_MOD(6), .T_ZQINIT(8)
  ) dutA (
    .core_clk(core_clk), .core_rst(core_rst), .ddr_init_start(ddr_init_start),
    .ddr_init_done(doneA), .busy(busyA), .dfi_reset_n(rstnA), .dfi_cke(ckeA),
    .dfi_cs_n(csA), .dfi_ras_n(rasA), .dfi_cas_n(casA), .dfi_we_n(weA),
    .dfi_bank(bankA), .dfi_address(addrA), .dfi_odt(odtA)
  );

  ddr_init_seq #(
    .T_RESET(0), .T_CKE(0), .T_XPR(0), .T_MRD(0), .T_MOD(0), .T_ZQINIT(0)
  ) dutZ (
    .core_clk(core_clk), .core_rst(core_rst), .ddr_init_start(ddr_init_start),
    .ddr_init_done(doneZ), .busy(busyZ), .dfi_reset_n(rstnZ), .dfi_cke(ckeZ),
    .dfi_cs_n(csZ), .dfi_ras_n(rasZ), .dfi_cas_n(casZ), .dfi_we_n(weZ),
    .dfi_bank(bankZ), .dfi_address(addrZ), .dfi_odt(odtZ)
  );

  // Compares one observed value against the bench's expectation.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drives inputs for the next sampling edge (called away from the edge).
  task automatic applyStimulus(input logic startVal, input logic rstVal);
    ddr_init_start = startVal;
    core_rst       = rstVal;
  endtask

  // Total cycles from the first RST_LOW cycle to the DONE cycle.
  function automatic int seqTotal(input int tR, tC, tX, tMrd, tMod, tZ);
    return tR + tC + tX + 3 * tMrd + tMod + tZ;
  endfunction

  // Expected pins packed as {done,busy,reset_n,cke,cs,ras,cas,we,odt,bank,addr}.
  function automatic logic [25:0] modelPins(input int mode, k, tR, tC, tX, tMrd, tMod);
    logic [13:0] mrVal [4];
    logic [2:0]  mrBank [4];
    logic        rstn, cke, cs, ras, cas, we, done, busy;
    logic [2:0]  bank;
    logic [13:0] addr;
    int mr2, zq;
    mrVal[0] = 14'h0008; mrVal[1] = 14'h0000; mrVal[2] = 14'h0044; mrVal[3] = 14'h0520;
    mrBank[0] = 3'd2;    mrBank[1] = 3'd3;    mrBank[2] = 3'd1;    mrBank[3] = 3'd0;
    rstn = 0; cke = 0; cs = 1; ras = 1; cas = 1; we = 1; done = 0; busy = 0;
    bank = 0; addr = 0;
    mr2 = tR + tC + tX;
    zq  = mr2 + 3 * tMrd + tMod;
    if (mode == 2) begin
      done = 1; rstn = 1; cke = 1; cs = 0;
    end else if (mode == 1) begin
      busy = 1;
      rstn = (k >= tR);
      cke  = (k >= tR + tC);
      cs   = !cke;
      for (int i = 0; i < 4; i++) begin
        if (k == mr2 + i * tMrd) begin
          ras = 0; cas = 0; we = 0; bank = mrBank[i]; addr = mrVal[i];
        end
      end
      if (k == zq) begin
        we = 0; addr = 14'h0400;
      end
    end
    return {done, busy, rstn, cke, cs, ras, cas, we, 1'b0, bank, addr};
  endfunction

  task automatic modelStep(input int total, inout int mode, inout int k);
    if (core_rst) begin
      mode = 0; k = 0;
    end else if (mode == 0) begin
      if (ddr_init_start) begin mode = 1; k = 0; end
    end else if (mode == 1) begin
      if (k + 1 == total) mode = 2;
      else k = k + 1;
    end else if (!ddr_init_start) begin
      mode = 0;
    end
  endtask

  // One clock: advance both models on the edge, check both DUTs at the negedge.
  task automatic stepCycle();
    @(posedge core_clk);
    modelStep(seqTotal(4, 5, 3, 4, 6, 8), modeA, kA);
    modelStep(seqTotal(1, 1, 1, 1, 1, 1), modeZ, kZ);
    @(negedge core_clk);
    checkOutput("pinsA", 32'({doneA, busyA, rstnA, ckeA, csA, rasA, casA, weA, odtA, bankA, addrA}),
                32'(modelPins(modeA, kA, 4, 5, 3, 4, 6)));
    checkOutput("pinsZ", 32'({doneZ, busyZ, rstnZ, ckeZ, csZ, rasZ, casZ, weZ, odtZ, bankZ, addrZ}),
                32'(modelPins(modeZ, kZ, 1, 1, 1, 1, 1)));
  endtask

  initial begin
    int doneAtA, doneAtZ, mr0Hits;
    logic startLvl;

    @(negedge core_clk);
    applyStimulus(1'b0, 1'b1);
    repeat (3) stepCycle();
    applyStimulus(1'b0, 1'b0);
    repeat (2) stepCycle();

    // Start held high through completion and well past it, then dropped.
    doneAtA = -1; doneAtZ = -1; mr0Hits = 0;
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 150; i++) begin
      stepCycle();
      if (doneA && doneAtA < 0) doneAtA = i;
      if (doneZ && doneAtZ < 0) doneAtZ = i;
      if (!csA && !rasA && !casA && !weA && bankA == 3'd0 && addrA == 14'h0520) mr0Hits++;
    end
    checkOutput("doneCycleA", 32'(doneAtA), 32'd38);
    checkOutput("doneCycleZ", 32'(doneAtZ), 32'd8);
    checkOutput("mr0Count", 32'(mr0Hits), 32'd1);
    applyStimulus(1'b0, 1'b0);
    stepCycle();
    checkOutput("doneDropped", 32'(doneA), 32'd0);
    repeat (3) stepCycle();

    // Single-cycle start pulse: full sequence, done for exactly one cycle.
    applyStimulus(1'b1, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 1'b0);
    doneAtA = 0;
    for (int i = 0; i < 50; i++) begin
      stepCycle();
      if (doneA) doneAtA++;
    end
    checkOutput("pulseDoneCycles", 32'(doneAtA), 32'd1);

    // Reset in the middle of the MRS phase, then a fresh start.
    applyStimulus(1'b1, 1'b0);
    repeat (19) stepCycle();
    applyStimulus(1'b0, 1'b1);
    stepCycle();
    checkOutput("midResetBusy", 32'(busyA), 32'd0);
    applyStimulus(1'b1, 1'b0);
    repeat (45) stepCycle();
    applyStimulus(1'b0, 1'b0);
    repeat (3) stepCycle();

    // Random start levels with occasional resets.
    startLvl = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 19) == 0) startLvl = ~startLvl;
      applyStimulus(startLvl, ($urandom_range(0, 249) == 0));
      stepCycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
